// File: rtl/newhope_pkg.sv
// Shared NewHope constants: stream widths, default RDI buffer depth and the modulus q.
package newhope_pkg;
  localparam int RDI_W     = 128;
  localparam int SHAKE_W   = 64;
  localparam int RDI_DEPTH = 4;
  localparam int NEWHOPE_Q = 12289;
endpackage

// File: rtl/rdi_fifo.sv
// Generic synchronous FIFO with a lookahead read port: while pop is high the next
// entry is shown, so a consumer acking in the same cycle sees the following entry.
module rdi_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CNT_W-1:0] count_q;
  logic             empty, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign rd_nxt  = rd_ptr_q + 1'b1;
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately left unreset; empty entries are masked on the read side.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if (pop && count_q >= CNT_W'(2)) rdata = mem_q[rd_nxt];
    else if (!empty)                 rdata = mem_q[rd_ptr_q];
  end
endmodule

// File: rtl/rdi_buffer.sv
// RDI producer: packs 64-bit SHAKE word pairs into 128-bit entries and queues them
// for the sampler. Optional underflow reporting (err/err_cnt) under RDI_BUFFER_ERR_EN.
module rdi_buffer
  import newhope_pkg::*;
#(
  parameter int DEPTH = RDI_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [SHAKE_W-1:0] in_data,
  output logic               in_ready,
  input  logic               rdi_ready,
  output logic [RDI_W-1:0]   rdi_data,
  output logic               rdi_valid,
  output logic [CNT_W-1:0]   count,
  output logic               full
`ifdef RDI_BUFFER_ERR_EN
  ,
  output logic               err,
  output logic [7:0]         err_cnt
`endif
);
  logic               half_q, half_d;
  logic [SHAKE_W-1:0] low_q, low_d;
  logic               accept, push;

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready && !flush;
  assign push      = accept && half_q;
  assign rdi_valid = (count != '0);

  always_comb begin
    half_d = half_q;
    low_d  = low_q;
    if (flush) begin
      half_d = 1'b0;
    end else if (accept) begin
      half_d = !half_q;
      if (!half_q) low_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q <= 1'b0;
      low_q  <= '0;
    end else begin
      half_q <= half_d;
      low_q  <= low_d;
    end
  end

  rdi_fifo #(.W(RDI_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .wdata ({in_data, low_q}),
    .pop   (rdi_ready),
    .rdata (rdi_data),
    .count (count),
    .full  (full)
  );

`ifdef RDI_BUFFER_ERR_EN
  logic       underflow;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign underflow = rdi_ready && (count == '0);

  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (flush) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else if (underflow) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_rdi_buffer.sv
// Self-checking bench for rdi_buffer: directed vector table, full/back-pressure and
// error sequences, then sampler-pattern and random traffic against a queue model.
`timescale 1ns/1ps
module tb_rdi_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, rdi_ready, rdi_valid, full;
  logic [63:0]      in_data;
  logic [127:0]     rdi_data;
  logic [CNT_W-1:0] count;
`ifdef RDI_BUFFER_ERR_EN
  logic             err;
  logic [7:0]       err_cnt;
`endif

  rdi_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rdi_ready(rdi_ready), .rdi_data(rdi_data),
    .rdi_valid(rdi_valid), .count(count), .full(full)
`ifdef RDI_BUFFER_ERR_EN
    , .err(err), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         fl, iv;
    logic [63:0]  d;
    logic         rr;
    int           cnt;
    logic [127:0] dat;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  // Reference model: a queue of completed entries plus the pending low half.
  logic [127:0] mq[$];
  logic         m_half;
  logic [63:0]  m_low;
  logic         m_err;
  int           m_ecnt;

  function automatic logic [63:0] w(input logic [3:0] n);
    return {16{n}};
  endfunction

  function automatic vec_t mk(input logic fl, input logic iv, input logic [63:0] d,
                              input logic rr, input int cnt, input logic [127:0] dat);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.rr = rr; v.cnt = cnt; v.dat = dat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_half = 1'b0;
    m_low  = '0;
    m_err  = 1'b0;
    m_ecnt = 0;
  endtask

  task automatic drive(input logic f, input logic v, input logic [63:0] d, input logic r);
    @(negedge clk);
    flush = f; in_valid = v; in_data = d; rdi_ready = r;
    #1;
  endtask

  task automatic model_check();
    int n;
    logic [127:0] ed;
    n  = mq.size();
    ed = '0;
    if (n > 0) ed = (rdi_ready && n >= 2) ? mq[1] : mq[0];
    chk("count", 128'(count), 128'(n));
    chk("rdi_valid", 128'(rdi_valid), 128'(n > 0));
    chk("full", 128'(full), 128'(n == DEPTH));
    chk("in_ready", 128'(in_ready), 128'(n != DEPTH));
    chk("rdi_data", rdi_data, ed);
`ifdef RDI_BUFFER_ERR_EN
    chk("err", 128'(err), 128'(m_err));
    chk("err_cnt", 128'(err_cnt), 128'(m_ecnt));
`endif
  endtask

  task automatic model_step();
    int n;
    n = mq.size();
    if (flush) begin
      mq.delete();
      m_half = 1'b0;
      m_err  = 1'b0;
      m_ecnt = 0;
    end else begin
      if (rdi_ready && n == 0) begin
        m_err = 1'b1;
        if (m_ecnt < 255) m_ecnt++;
      end
      if (rdi_ready && n > 0) begin
        $display("pop %0d entry %h", n_pop, mq[0]);
        void'(mq.pop_front());
        n_pop++;
      end
      if (in_valid && n < DEPTH) begin
        if (m_half) begin
          mq.push_back({in_data, m_low});
          m_half = 1'b0;
        end else begin
          m_low  = in_data;
          m_half = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(input logic f, input logic v, input logic [63:0] d, input logic r);
    drive(f, v, d, r);
    model_check();
    model_step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".count"}, 128'(count), 128'(0));
    chk({tag, ".rdi_valid"}, 128'(rdi_valid), 128'(0));
    chk({tag, ".full"}, 128'(full), 128'(0));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, ".rdi_data"}, rdi_data, 128'(0));
`ifdef RDI_BUFFER_ERR_EN
    chk({tag, ".err"}, 128'(err), 128'(0));
    chk({tag, ".err_cnt"}, 128'(err_cnt), 128'(0));
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    flush = 0; in_valid = 0; in_data = '0; rdi_ready = 0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[19];

    rst_n = 1'b0; flush = 0; in_valid = 0; in_data = '0; rdi_ready = 0;
    model_reset();
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    tv[0]  = mk(0, 0, '0,    0, 0, '0);
    tv[1]  = mk(0, 1, w(1),  0, 0, '0);
    tv[2]  = mk(0, 1, w(2),  0, 0, '0);
    tv[3]  = mk(0, 0, '0,    0, 1, {w(2), w(1)});
    tv[4]  = mk(0, 1, w(3),  0, 1, {w(2), w(1)});
    tv[5]  = mk(0, 1, w(4),  0, 1, {w(2), w(1)});
    tv[6]  = mk(0, 0, '0,    0, 2, {w(2), w(1)});
    tv[7]  = mk(0, 0, '0,    1, 2, {w(4), w(3)});
    tv[8]  = mk(0, 0, '0,    0, 1, {w(4), w(3)});
    tv[9]  = mk(0, 0, '0,    1, 1, {w(4), w(3)});
    tv[10] = mk(0, 0, '0,    0, 0, '0);
    tv[11] = mk(0, 0, '0,    1, 0, '0);
    tv[12] = mk(0, 1, w(5),  0, 0, '0);
    tv[13] = mk(1, 1, w(6),  1, 0, '0);
    tv[14] = mk(0, 1, w(7),  0, 0, '0);
    tv[15] = mk(0, 1, w(8),  0, 0, '0);
    tv[16] = mk(0, 0, '0,    0, 1, {w(8), w(7)});
    tv[17] = mk(1, 0, '0,    0, 1, {w(8), w(7)});
    tv[18] = mk(0, 0, '0,    0, 0, '0);

    for (int i = 0; i < 19; i++) begin
      drive(tv[i].fl, tv[i].iv, tv[i].d, tv[i].rr);
      $display("vec %0d fl=%0b iv=%0b rr=%0b count=%0d data=%h",
               i, tv[i].fl, tv[i].iv, tv[i].rr, count, rdi_data);
      chk($sformatf("v%0d.count", i), 128'(count), 128'(tv[i].cnt));
      chk($sformatf("v%0d.rdi_valid", i), 128'(rdi_valid), 128'(tv[i].cnt > 0));
      chk($sformatf("v%0d.full", i), 128'(full), 128'(tv[i].cnt == DEPTH));
      chk($sformatf("v%0d.in_ready", i), 128'(in_ready), 128'(tv[i].cnt != DEPTH));
      chk($sformatf("v%0d.rdi_data", i), rdi_data, tv[i].dat);
      model_step();
    end

    // Back-pressure: eight words fill the FIFO, the ninth waits for one pop.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(0, 1, {$urandom(), $urandom()}, 0);
    drive(0, 1, w(9), 0);
    chk("fill.full", 128'(full), 128'(1));
    chk("fill.in_ready", 128'(in_ready), 128'(0));
    model_step();
    cycle(0, 1, w(9), 0);
    cycle(0, 1, w(9), 1);
    drive(0, 1, w(9), 0);
    chk("held.in_ready", 128'(in_ready), 128'(1));
    chk("held.count", 128'(count), 128'(3));
    model_step();
    cycle(0, 1, w(10), 0);
    cycle(0, 0, '0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1);

`ifdef RDI_BUFFER_ERR_EN
    cycle(1, 0, '0, 0);
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 1);
    drive(0, 0, '0, 0);
    chk("uf.err", 128'(err), 128'(1));
    chk("uf.err_cnt", 128'(err_cnt), 128'(2));
    model_step();
    cycle(1, 0, '0, 0);
    drive(0, 0, '0, 0);
    chk("ufclr.err", 128'(err), 128'(0));
    chk("ufclr.err_cnt", 128'(err_cnt), 128'(0));
    model_step();
`endif

    // Sampler pattern: continuous supply, one consume every ninth cycle, 64 rows.
    do_reset();
    for (int c = 0; c < 64 * 9; c++) cycle(0, 1, {$urandom(), $urandom()}, (c % 9) == 8);

    // Random traffic with a reset asserted mid-stream.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            {$urandom(), $urandom()}, ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
